// File: rtl/booth_pkg.sv
// Shared types and arithmetic for the Booth product accumulator.
// Build option BOOTH_ACC_SAT_EN: saturate instead of wrapping on signed overflow.
package booth_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int PW_DEF    = 8;
  localparam int ACC_W_DEF = 16;
  // Internal working width; accumulator widths up to MAX_W-1 are supported.
  localparam int MAX_W     = 64;

  typedef struct packed {
    logic                    ovf;
    logic signed [MAX_W-1:0] sum;
  } add_res_t;

  // a and b are already sign-extended from w bits; the sum is exact in MAX_W bits,
  // so it overflows w bits exactly when it leaves the w-bit signed range.
  function automatic add_res_t sat_add(input logic signed [MAX_W-1:0] a,
                                       input logic signed [MAX_W-1:0] b,
                                       input int                      w);
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    logic signed [MAX_W-1:0] s;
    add_res_t                r;
    hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo    = -hi - 64'sd1;
    s     = a + b;
    r.ovf = (s > hi) || (s < lo);
    r.sum = s;
`ifdef BOOTH_ACC_SAT_EN
    if (r.ovf) r.sum = a[MAX_W-1] ? lo : hi;
`endif
    return r;
  endfunction

endpackage

// File: rtl/booth_acc_add.sv
// Combinational sign-extend / add / overflow / optional clamp for one product term.
module booth_acc_add
  import booth_pkg::*;
#(
  parameter int PW    = PW_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc_in,
  input  logic [PW-1:0]    prod,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic signed [MAX_W-1:0] a_ext;
  logic signed [MAX_W-1:0] b_ext;
  add_res_t                res;
  logic                    unused_hi;

  always_comb begin
    a_ext = MAX_W'($signed(acc_in));
    b_ext = MAX_W'($signed(prod));
    res   = sat_add(a_ext, b_ext, ACC_W);
    sum   = res.sum[ACC_W-1:0];
    ovf   = res.ovf;
  end

  assign unused_hi = ^res.sum[MAX_W-1:ACC_W];

endmodule

// File: rtl/booth_prod_acc.sv
// Accumulates up to N_TERMS signed products per block and holds each block result
// on a registered valid/ready port. Build option BOOTH_ACC_SAT_EN selects saturation.
module booth_prod_acc
  import booth_pkg::*;
#(
  parameter int  PW      = PW_DEF,
  parameter int  ACC_W   = ACC_W_DEF,
  parameter int  N_TERMS = 4,
  localparam int CW      = $clog2(N_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CW-1:0]    out_count,
  output logic             out_ovf
);

  // Handshake: a term transfers on a rising clk edge when in_valid && in_ready;
  // a result transfers when out_valid && out_ready. In HOLD, in_ready follows
  // out_ready combinationally so a drain and a new first term share one edge.

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_acc_q, out_acc_d;
  logic [CW-1:0]      out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;

  logic [ACC_W-1:0]   add_base;
  logic [ACC_W-1:0]   add_sum;
  logic               add_ovf;
  logic               closes;

  // A term taken while draining starts a fresh block, so it adds to zero.
  assign add_base = (state_q == HOLD) ? '0 : acc_q;

  booth_acc_add #(
    .PW    (PW),
    .ACC_W (ACC_W)
  ) u_add (
    .acc_in (add_base),
    .prod   (in_prod),
    .sum    (add_sum),
    .ovf    (add_ovf)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    in_ready    = 1'b0;
    closes      = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d  = add_sum;
          cnt_d  = cnt_q + CW'(1);
          ovf_d  = ovf_q | add_ovf;
          closes = (cnt_d == CW'(N_TERMS)) || in_last;
        end
      end
      HOLD: begin
        in_ready = out_ready;
        if (out_ready) begin
          state_d     = ACCUM;
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          if (in_valid) begin
            acc_d  = add_sum;
            cnt_d  = CW'(1);
            ovf_d  = add_ovf;
            closes = (cnt_d == CW'(N_TERMS)) || in_last;
          end
        end
      end
      default: ;
    endcase
    if (closes) begin
      state_d     = HOLD;
      out_valid_d = 1'b1;
      out_acc_d   = acc_d;
      out_count_d = cnt_d;
      out_ovf_d   = ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_booth_prod_acc.sv
// Bench for booth_prod_acc: three configurations (default, ACC_W=8, N_TERMS=1)
// checked against a block-level reference model; honours BOOTH_ACC_SAT_EN.
module tb_booth_prod_acc;

  typedef struct packed {
    logic [31:0] acc;
    logic [31:0] cnt;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       tb_valid, tb_last, tb_oready;
  logic [7:0] tb_prod;
  int         act;
  int         cfg_w, cfg_n;

  logic        rdy0, ov0, of0;
  logic [15:0] acc0;
  logic [2:0]  cnt0;
  logic        rdy1, ov1, of1;
  logic [7:0]  acc1;
  logic [2:0]  cnt1;
  logic        rdy2, ov2, of2;
  logic [15:0] acc2;
  logic [0:0]  cnt2;

  booth_prod_acc u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(tb_valid && act == 0), .in_ready(rdy0),
    .in_prod(tb_prod), .in_last(tb_last), .out_valid(ov0), .out_ready(tb_oready),
    .out_acc(acc0), .out_count(cnt0), .out_ovf(of0)
  );

  booth_prod_acc #(.ACC_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(tb_valid && act == 1), .in_ready(rdy1),
    .in_prod(tb_prod), .in_last(tb_last), .out_valid(ov1), .out_ready(tb_oready),
    .out_acc(acc1), .out_count(cnt1), .out_ovf(of1)
  );

  booth_prod_acc #(.N_TERMS(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(tb_valid && act == 2), .in_ready(rdy2),
    .in_prod(tb_prod), .in_last(tb_last), .out_valid(ov2), .out_ready(tb_oready),
    .out_acc(acc2), .out_count(cnt2), .out_ovf(of2)
  );

  logic [31:0] obs_ready, obs_valid, obs_acc, obs_cnt, obs_ovf;

  always_comb begin
    obs_ready = 32'(rdy0);
    obs_valid = 32'(ov0);
    obs_acc   = 32'($signed(acc0));
    obs_cnt   = 32'(cnt0);
    obs_ovf   = 32'(of0);
    if (act == 1) begin
      obs_ready = 32'(rdy1);
      obs_valid = 32'(ov1);
      obs_acc   = 32'($signed(acc1));
      obs_cnt   = 32'(cnt1);
      obs_ovf   = 32'(of1);
    end else if (act == 2) begin
      obs_ready = 32'(rdy2);
      obs_valid = 32'(ov2);
      obs_acc   = 32'($signed(acc2));
      obs_cnt   = 32'(cnt2);
      obs_ovf   = 32'(of2);
    end
  end

  int   n_cmp = 0;
  int   n_err = 0;
  int   cur[$];
  res_t pend[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s (cfg %0d): observed %0d expected %0d", tag, act, $signed(got), $signed(exp));
    end
  endtask

  // Block sum from the arithmetic rules: exact integer add, then wrap or clamp.
  function automatic res_t block_result();
    longint hi, lo, acc, t;
    res_t   r;
    hi    = (longint'(1) <<< (cfg_w - 1)) - 1;
    lo    = -hi - 1;
    acc   = 0;
    r.ovf = 1'b0;
    foreach (cur[i]) begin
      t = acc + longint'(cur[i]);
      if (t > hi || t < lo) begin
        r.ovf = 1'b1;
`ifdef BOOTH_ACC_SAT_EN
        acc = (t > hi) ? hi : lo;
`else
        acc = (t > hi) ? t - 2 * (hi + 1) : t + 2 * (hi + 1);
`endif
      end else begin
        acc = t;
      end
    end
    r.acc = 32'(acc);
    r.cnt = 32'(cur.size());
    return r;
  endfunction

  // Called at a falling edge: drive, check, advance the model, move to the next falling edge.
  task automatic step(input logic v, input int p, input logic l, input logic ordy);
    logic exp_rdy;
    tb_valid  = v;
    tb_prod   = 8'(p);
    tb_last   = l;
    tb_oready = ordy;
    #1;
    exp_rdy = (pend.size() == 0) || ordy;
    chk("in_ready", obs_ready, 32'(exp_rdy));
    chk("out_valid", obs_valid, 32'(pend.size() != 0));
    if (pend.size() != 0) begin
      chk("out_acc", obs_acc, pend[0].acc);
      chk("out_count", obs_cnt, pend[0].cnt);
      chk("out_ovf", obs_ovf, 32'(pend[0].ovf));
      if (ordy) void'(pend.pop_front());
    end
    if (v && exp_rdy) begin
      cur.push_back(p);
      if (cur.size() == cfg_n || l) begin
        pend.push_back(block_result());
        cur.delete();
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, obs_valid, 0);
    chk({tag, "_acc"}, obs_acc, 0);
    chk({tag, "_count"}, obs_cnt, 0);
    chk({tag, "_ovf"}, obs_ovf, 0);
    chk({tag, "_in_ready"}, obs_ready, 1);
  endtask

  task automatic async_reset(input string tag);
    tb_valid = 1'b0;
    tb_last  = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk_zero(tag);
    pend.delete();
    cur.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic select_cfg(input int a, input int w, input int n);
    tb_valid  = 1'b0;
    tb_last   = 1'b0;
    tb_oready = 1'b0;
    rst_n     = 1'b0;
    pend.delete();
    cur.delete();
    act   = a;
    cfg_w = w;
    cfg_n = n;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step(($urandom_range(0, 99) < 60), int'($urandom_range(0, 255)) - 128,
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 99) < 70));
    end
  endtask

  initial begin
    tb_valid  = 1'b0;
    tb_prod   = 8'd0;
    tb_last   = 1'b0;
    tb_oready = 1'b0;
    act       = 0;
    cfg_w     = 16;
    cfg_n     = 4;
    rst_n     = 1'b0;
    @(negedge clk);
    #1;
    chk_zero("reset");
    select_cfg(0, 16, 4);

    // 64 x 4 with the consumer always ready
    repeat (4) step(1, 64, 0, 1);
    chk("d1_valid", obs_valid, 1);
    chk("d1_acc", obs_acc, 256);
    chk("d1_count", obs_cnt, 4);
    chk("d1_ovf", obs_ovf, 0);
    step(0, 0, 0, 1);

    // early close, then a negative block
    step(1, 10, 0, 1);
    step(1, -3, 1, 1);
    chk("d2_acc", obs_acc, 7);
    chk("d2_count", obs_cnt, 2);
    step(0, 0, 0, 1);
    repeat (4) step(1, -56, 0, 1);
    chk("d3_acc", obs_acc, -224);
    chk("d3_count", obs_cnt, 4);

    // backpressure, ignored input while held, then drain plus a new first term
    repeat (3) step(0, 0, 0, 0);
    step(1, 99, 0, 0);
    chk("bp_acc", obs_acc, -224);
    step(1, 5, 0, 1);
    chk("b2b_valid", obs_valid, 0);
    repeat (3) step(1, 1, 0, 1);
    chk("b2b_acc", obs_acc, 8);
    chk("b2b_count", obs_cnt, 4);
    step(0, 0, 0, 1);

    // reset mid-block and mid-hold
    step(1, 64, 0, 1);
    step(1, 64, 0, 1);
    async_reset("rst_mid");
    step(1, 1, 0, 1);
    step(1, 2, 0, 1);
    step(1, 3, 0, 1);
    step(1, 4, 0, 0);
    chk("rst_fresh_acc", obs_acc, 10);
    step(0, 0, 0, 1);
    repeat (4) step(1, 7, 0, 0);
    step(0, 0, 0, 0);
    async_reset("rst_hold");
    random_run(250);

    // narrow accumulator: overflow behaviour
    select_cfg(1, 8, 4);
    step(1, 64, 0, 1);
    step(1, 64, 1, 1);
`ifdef BOOTH_ACC_SAT_EN
    chk("w8_acc", obs_acc, 127);
`else
    chk("w8_acc", obs_acc, -128);
`endif
    chk("w8_ovf", obs_ovf, 1);
    step(0, 0, 0, 1);
    step(1, 64, 0, 1);
    step(1, -64, 1, 1);
    chk("w8_acc2", obs_acc, 0);
    chk("w8_ovf2", obs_ovf, 0);
    step(0, 0, 0, 1);
    random_run(250);

    // single-term blocks streamed with no bubbles
    select_cfg(2, 16, 1);
    for (int i = 0; i < 20; i++) begin
      step(1, int'($urandom_range(0, 255)) - 128, 0, 1);
      chk("n1_valid", obs_valid, 1);
    end
    random_run(150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
